// File: rtl/register_file_2r1w.sv
// ---------------------------------------------------------------------------
// register_file_2r1w
// Two-read / one-write register file with registered (1-cycle) reads and a
// hardware clear sequencer that zeroes registers 1..N_REGS-1, one per cycle.
// Register 0 is hardwired to zero.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   when defined, a write performed in a cycle is forwarded to any read port
//   addressing the same register in that cycle. When undefined, reads are
//   read-before-write.
//
// Parameters:
//   DW        data width (1..64)
//   AW        address width, N_REGS = 2**AW (1..6)
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   in        write data
//   ld        write request
//   addr_W    write address
//   addr_A    read address, port A
//   addr_B    read address, port B
//   out_A     registered read data, port A
//   out_B     registered read data, port B
//   clr       request to clear all registers
//   busy      high while a clear sequence runs (registered)
//   wr_drop   one-cycle pulse when a requested write was discarded
// ---------------------------------------------------------------------------
module register_file_2r1w #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in,
    input  logic          ld,
    input  logic [AW-1:0] addr_W,
    input  logic [AW-1:0] addr_A,
    input  logic [AW-1:0] addr_B,
    output logic [DW-1:0] out_A,
    output logic [DW-1:0] out_B,
    input  logic          clr,
    output logic          busy,
    output logic          wr_drop
);

    localparam int unsigned N_REGS = 1 << AW;
    localparam logic [AW-1:0] LAST_IDX = AW'(N_REGS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   regs_q [N_REGS];
    logic [DW-1:0]   regs_d [N_REGS];
    logic [DW-1:0]   out_a_q, out_a_d;
    logic [DW-1:0]   out_b_q, out_b_d;
    logic            busy_q, busy_d;
    logic            wr_drop_q, wr_drop_d;

    logic            wr_req;
    logic            wr_en;

    // A write to address 0 is not a request at all: ignored without a drop pulse.
    assign wr_req = ld && (addr_W != '0);
    assign wr_en  = wr_req && (state_q == IDLE) && !clr;

    // Next-state: FSM, clear counter, storage, read ports and flags.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        regs_d    = regs_q;
        out_a_d   = regs_q[addr_A];
        out_b_d   = regs_q[addr_B];
        wr_drop_d = wr_req && ((state_q == CLEAR) || clr);

        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = AW'(1);
                end
            end
            CLEAR: begin
                // clr is ignored here: the running sequence is not restarted.
                regs_d[cnt_q] = '0;
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (wr_en) begin
            regs_d[addr_W] = in;
        end

`ifdef REGFILE_BYPASS_EN
        // Forward only writes that actually happen (never address 0 or drops).
        if (wr_en && (addr_A == addr_W)) begin
            out_a_d = in;
        end
        if (wr_en && (addr_B == addr_W)) begin
            out_b_d = in;
        end
`endif

        // Register 0 stays zero regardless of any path above.
        regs_d[0] = '0;

        busy_d = (state_d == CLEAR);
    end

    // State register with asynchronous reset of everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out_a_q   <= '0;
            out_b_q   <= '0;
            busy_q    <= 1'b0;
            wr_drop_q <= 1'b0;
            for (int i = 0; i < int'(N_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_a_q   <= out_a_d;
            out_b_q   <= out_b_d;
            busy_q    <= busy_d;
            wr_drop_q <= wr_drop_d;
            for (int i = 0; i < int'(N_REGS); i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign out_A   = out_a_q;
    assign out_B   = out_b_q;
    assign busy    = busy_q;
    assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_register_file_2r1w.sv
// ---------------------------------------------------------------------------
// tb_register_file_2r1w
// Directed, self-checking bench for register_file_2r1w (DW=8, AW=3).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_register_file_2r1w;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in;
    logic          ld;
    logic [AW-1:0] addr_W;
    logic [AW-1:0] addr_A;
    logic [AW-1:0] addr_B;
    logic [DW-1:0] out_A;
    logic [DW-1:0] out_B;
    logic          clr;
    logic          busy;
    logic          wr_drop;

    int n_cmp = 0;
    int n_err = 0;

    register_file_2r1w #(.DW(DW), .AW(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in),
        .ld      (ld),
        .addr_W  (addr_W),
        .addr_A  (addr_A),
        .addr_B  (addr_B),
        .out_A   (out_A),
        .out_B   (out_B),
        .clr     (clr),
        .busy    (busy),
        .wr_drop (wr_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld = 1'b1; addr_W = a; in = d;
        tick();
        ld = 1'b0;
    endtask

    logic [DW-1:0] exp_byp;

    initial begin
        rst_n = 1'b1; in = '0; ld = 1'b0; addr_W = '0; addr_A = '0; addr_B = '0; clr = 1'b0;

        // Asynchronous reset: outputs clear before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_A", 64'(out_A), 64'h0);
        check("rst_out_B", 64'(out_B), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_wr_drop", 64'(wr_drop), 64'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Basic write then read; port B on address 0.
        write(3'd3, 8'hA5);
        addr_A = 3'd3; addr_B = 3'd0;
        tick();
        check("rd_A_reg3", 64'(out_A), 64'hA5);
        check("rd_B_reg0", 64'(out_B), 64'h00);
        check("no_drop_basic", 64'(wr_drop), 64'h0);

        // Write to address 0 is ignored silently.
        write(3'd0, 8'hFF);
        check("no_drop_addr0", 64'(wr_drop), 64'h0);
        addr_A = 3'd0;
        tick();
        check("rd_reg0_zero", 64'(out_A), 64'h00);
        check("no_drop_addr0_b", 64'(wr_drop), 64'h0);

        // Both ports on the same address.
        addr_A = 3'd3; addr_B = 3'd3;
        tick();
        check("same_addr_A", 64'(out_A), 64'hA5);
        check("same_addr_B", 64'(out_B), 64'hA5);

        // Same-cycle read and write of one register.
        write(3'd5, 8'h11);
        addr_A = 3'd5;
        ld = 1'b1; addr_W = 3'd5; in = 8'h3C;
`ifdef REGFILE_BYPASS_EN
        exp_byp = 8'h3C;
`else
        exp_byp = 8'h11;
`endif
        tick();
        ld = 1'b0;
        check("rw_same_cycle", 64'(out_A), 64'(exp_byp));
        tick();
        check("rw_after", 64'(out_A), 64'h3C);

        // Load all registers with 0x10+i and spot-check.
        for (int i = 1; i < 8; i++) write(AW'(i), DW'(8'h10 + i));
        addr_A = 3'd1; addr_B = 3'd7;
        tick();
        check("load_reg1", 64'(out_A), 64'h11);
        check("load_reg7", 64'(out_B), 64'h17);

        // Clear sequence: busy for 7 cycles, write during busy is dropped.
        clr = 1'b1;
        tick();                              // IDLE -> CLEAR, cnt=1
        check("clr_busy_0", 64'(busy), 64'h1);
        clr = 1'b1;                          // ignored while clearing
        ld = 1'b1; addr_W = 3'd4; in = 8'hEE;
        addr_A = 3'd6; addr_B = 3'd4;
        tick();                              // clears reg1
        clr = 1'b0; ld = 1'b0;
        check("clr_busy_1", 64'(busy), 64'h1);
        check("clr_drop", 64'(wr_drop), 64'h1);
        check("clr_rd_uncleared", 64'(out_A), 64'h16);
        check("clr_rd_noupdate", 64'(out_B), 64'h14);
        for (int i = 2; i < 7; i++) begin
            tick();
            check($sformatf("clr_busy_%0d", i), 64'(busy), 64'h1);
        end
        check("clr_drop_pulse_end", 64'(wr_drop), 64'h0);
        tick();
        check("clr_busy_done", 64'(busy), 64'h0);
        tick();
        check("clr_no_restart", 64'(busy), 64'h0);
        for (int i = 0; i < 8; i++) begin
            addr_A = AW'(i); addr_B = AW'(7 - i);
            tick();
            check($sformatf("clr_zero_A%0d", i), 64'(out_A), 64'h0);
            check($sformatf("clr_zero_B%0d", i), 64'(out_B), 64'h0);
        end

        // clr and ld in the same IDLE cycle: clr wins, write dropped.
        clr = 1'b1; ld = 1'b1; addr_W = 3'd2; in = 8'h77;
        tick();
        clr = 1'b0; ld = 1'b0;
        check("clrld_drop", 64'(wr_drop), 64'h1);
        check("clrld_busy", 64'(busy), 64'h1);
        for (int i = 0; i < 7; i++) tick();
        check("clrld_done", 64'(busy), 64'h0);
        addr_A = 3'd2;
        tick();
        check("clrld_reg2", 64'(out_A), 64'h0);

        // Reset mid-clear (cnt=3) aborts everything immediately.
        write(3'd3, 8'h33);
        write(3'd7, 8'h77);
        addr_A = 3'd7; addr_B = 3'd3;
        clr = 1'b1;
        tick();                              // cnt=1
        clr = 1'b0;
        tick();                              // cnt=2
        tick();                              // cnt=3
        check("pre_rst_busy", 64'(busy), 64'h1);
        check("pre_rst_A", 64'(out_A), 64'h77);
        check("pre_rst_B", 64'(out_B), 64'h33);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'h0);
        check("midrst_A", 64'(out_A), 64'h0);
        check("midrst_B", 64'(out_B), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("postrst_busy", 64'(busy), 64'h0);
        for (int i = 0; i < 8; i++) begin
            addr_A = AW'(i); addr_B = AW'(i);
            tick();
            check($sformatf("postrst_A%0d", i), 64'(out_A), 64'h0);
            check($sformatf("postrst_B%0d", i), 64'(out_B), 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
